// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer.
// Used by mac_seq_ctrl and the layer scheduler.
package mac_seq_pkg;

  localparam int MAX_READ_LAT = 4;
  localparam int DRAIN_W = $clog2(MAX_READ_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } mac_seq_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        relu_applied;
  } mac_seq_res_t;

  function automatic mac_seq_res_t relu32(
    input logic [31:0] acc
  );
    mac_seq_res_t r;
    r.relu_applied = acc[31];
    r.data = acc[31] ? 32'd0 : acc;
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Command, buffer, MAC and result bundle
// between scheduler/MAC lane and the sequencer.
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int ACC_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_act_base;
  logic [ADDR_W-1:0] cmd_wgt_base;
  logic              cmd_abort;
  logic              op_avail;
  logic              rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic              mac_enable;
  logic              mac_clear_acc;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              busy;

  modport master (
    output cmd_valid, cmd_len,
    output cmd_act_base, cmd_wgt_base,
    output cmd_abort, op_avail,
    output mac_acc, res_ready,
    input  cmd_ready, rd_en,
    input  act_addr, wgt_addr,
    input  mac_enable, mac_clear_acc,
    input  res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_len,
    input  cmd_act_base, cmd_wgt_base,
    input  cmd_abort, op_avail,
    input  mac_acc, res_ready,
    output cmd_ready, rd_en,
    output act_addr, wgt_addr,
    output mac_enable, mac_clear_acc,
    output res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_seq_lat_pipe.sv
// DEPTH-deep 1-bit delay line, synchronous flush.
// Aligns mac_enable to buffer read latency.
module mac_seq_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // shift in one bit per cycle, flush wipes all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(din);
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one INT8 MAC lane.
// Define MAC_SEQ_RELU_EN to clamp negative results.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 11,
  parameter int ACC_W    = 32,
  parameter int READ_LAT = 1
) (
  input logic     clk,
  input logic     rst_n,
  mac_seq_ctrl_if.slave bus
);

  mac_seq_state_t    state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] act_base_q;
  logic [ADDR_W-1:0] wgt_base_q;
  logic [ADDR_W-1:0] act_last;
  logic [ADDR_W-1:0] wgt_last;
  logic [ADDR_W-1:0] act_cur;
  logic [ADDR_W-1:0] wgt_cur;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [ACC_W-1:0]  out_data;
  logic              rd_en;
  logic              abort;

  assign abort = bus.cmd_abort
               & (state != IDLE);
  assign rd_en = (state == RUN)
               & bus.op_avail;
  assign act_cur = act_base_q + ADDR_W'(idx);
  assign wgt_cur = wgt_base_q + ADDR_W'(idx);

  // command sequencing; abort beats everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      idx        <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      drain_cnt  <= '0;
    end else if (abort) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            len_q      <= bus.cmd_len;
            act_base_q <= bus.cmd_act_base;
            wgt_base_q <= bus.cmd_wgt_base;
            idx        <= '0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          state <= (len_q != '0) ? RUN : DONE;
        end
        RUN: begin
          if (bus.op_avail) begin
            idx <= idx + LEN_W'(1);
            if (idx == len_q - LEN_W'(1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(READ_LAT - 1))
            state <= DONE;
          else
            drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // keep last issued address while idle/stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_last <= '0;
      wgt_last <= '0;
    end else if (rd_en) begin
      act_last <= act_cur;
      wgt_last <= wgt_cur;
    end
  end

  mac_seq_lat_pipe #(
    .DEPTH (READ_LAT)
  ) u_en_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .din   (rd_en),
    .dout  (bus.mac_enable)
  );

`ifdef MAC_SEQ_RELU_EN
  assign out_data = bus.mac_acc[ACC_W-1]
                  ? '0 : bus.mac_acc;
`else
  assign out_data = bus.mac_acc;
`endif

  assign bus.cmd_ready     = (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.mac_clear_acc = (state == CLEAR);
  assign bus.res_valid     = (state == DONE);
  assign bus.res_data      = (state == DONE)
                           ? out_data : '0;
  assign bus.rd_en    = rd_en;
  assign bus.act_addr = rd_en ? act_cur : act_last;
  assign bus.wgt_addr = rd_en ? wgt_cur : wgt_last;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl, READ_LAT=1 and 3.
// Honours MAC_SEQ_RELU_EN for expected results.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        sel = 1'b0;
  logic        cv_a = 1'b0;
  logic        cv_b = 1'b0;
  logic [10:0] len = '0;
  logic [9:0]  ab = '0;
  logic [9:0]  wb = '0;
  logic        abort = 1'b0;
  logic        avail = 1'b0;
  logic        rready = 1'b0;
  int          acc_a, acc_b, pa;
  int          pb [3];

  mac_seq_ctrl_if ba ();
  mac_seq_ctrl_if bb ();

  mac_seq_ctrl #(.READ_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ba));
  mac_seq_ctrl #(.READ_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bb));

  assign ba.cmd_valid    = cv_a;
  assign ba.cmd_len      = len;
  assign ba.cmd_act_base = ab;
  assign ba.cmd_wgt_base = wb;
  assign ba.cmd_abort    = abort;
  assign ba.op_avail     = avail;
  assign ba.res_ready    = rready;
  assign ba.mac_acc      = acc_a;
  assign bb.cmd_valid    = cv_b;
  assign bb.cmd_len      = len;
  assign bb.cmd_act_base = ab;
  assign bb.cmd_wgt_base = wb;
  assign bb.cmd_abort    = abort;
  assign bb.op_avail     = avail;
  assign bb.res_ready    = rready;
  assign bb.mac_acc      = acc_b;

  logic        o_rd, o_en, o_clr, o_rv;
  logic        o_crdy, o_busy;
  logic [9:0]  o_aa, o_wa;
  logic [31:0] o_data;
  assign o_rd   = sel ? bb.rd_en : ba.rd_en;
  assign o_en   = sel ? bb.mac_enable : ba.mac_enable;
  assign o_clr  = sel ? bb.mac_clear_acc
                      : ba.mac_clear_acc;
  assign o_rv   = sel ? bb.res_valid : ba.res_valid;
  assign o_crdy = sel ? bb.cmd_ready : ba.cmd_ready;
  assign o_busy = sel ? bb.busy : ba.busy;
  assign o_aa   = sel ? bb.act_addr : ba.act_addr;
  assign o_wa   = sel ? bb.wgt_addr : ba.wgt_addr;
  assign o_data = sel ? bb.res_data : ba.res_data;

  function automatic int actv(input logic [9:0] a);
    return int'(a[3:0]) - 8;
  endfunction

  function automatic int wgtv(input logic [9:0] a);
    return int'(a[2:0]) + 1;
  endfunction

  function automatic logic [31:0] rl(input int x);
`ifdef MAC_SEQ_RELU_EN
    return (x < 0) ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  // operand buffers + MAC lane, latency 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa <= 0;
      acc_a <= 0;
    end else begin
      pa <= ba.rd_en ? actv(ba.act_addr)
                       * wgtv(ba.wgt_addr) : 0;
      if (ba.mac_clear_acc) acc_a <= 0;
      else if (ba.mac_enable) acc_a <= acc_a + pa;
    end
  end

  // operand buffers + MAC lane, latency 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb[0] <= 0;
      pb[1] <= 0;
      pb[2] <= 0;
      acc_b <= 0;
    end else begin
      pb[0] <= bb.rd_en ? actv(bb.act_addr)
                          * wgtv(bb.wgt_addr) : 0;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
      if (bb.mac_clear_acc) acc_b <= 0;
      else if (bb.mac_enable) acc_b <= acc_b + pb[2];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    int          k;
    logic [9:0]  ab;
    logic [9:0]  wb;
    logic [31:0] avail;
    int          hold;
    int          lat;
    logic [31:0] data;
  } vec_t;

  task automatic run_cmd(input logic s,
                         input vec_t v);
    int nrd = 0;
    int nen = 0;
    int nclr = 0;
    int clr_at = -1;
    int err = 0;
    int lat = -1;
    int lt;
    bit rdh [256];
    lt = s ? 3 : 1;
    sel = s;
    @(negedge clk);
    len = 11'(v.k);
    ab = v.ab;
    wb = v.wb;
    avail = v.avail[0];
    rready = 1'b0;
    if (s) cv_b = 1'b1;
    else cv_a = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      cv_a = 1'b0;
      cv_b = 1'b0;
      avail = v.avail[c % 32];
      #1;
      rdh[c] = o_rd;
      if (o_clr) begin
        nclr++;
        if (clr_at < 0) clr_at = c;
      end
      if (o_clr && o_en) err++;
      if (o_rd) begin
        if (o_aa !== v.ab + 10'(nrd)) err++;
        if (o_wa !== v.wb + 10'(nrd)) err++;
        nrd++;
      end else if (nrd > 0) begin
        if (o_aa !== v.ab + 10'(nrd - 1)) err++;
      end
      if (o_en) begin
        nen++;
        if (c < lt || !rdh[c-lt]) err++;
      end
      if (o_rv) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, v.lat);
    chk("res_data", o_data, v.data);
    chk("rd_count", nrd, v.k);
    chk("en_count", nen, v.k);
    chk("clr_count", nclr, 1);
    chk("clr_first", clr_at, 1);
    chk("seq_errors", err, 0);
    for (int h = 0; h < v.hold; h++) begin
      if (s) cv_b = 1'b1;
      else cv_a = 1'b1;
      rready = 1'b0;
      @(negedge clk);
      #1;
      chk("hold_valid", o_rv, 1);
      chk("hold_data", o_data, v.data);
      chk("hold_crdy", o_crdy, 0);
    end
    cv_a = 1'b0;
    cv_b = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    #1;
    chk("post_valid", o_rv, 0);
    chk("post_crdy", o_crdy, 1);
    chk("post_data", o_data, 0);
  endtask

  vec_t vt [6];
  int ne, nv;

  initial begin
    vt[0] = '{4, 10'h010, 10'h200, '1, 0, 7, rl(-60)};
    vt[1] = '{3, 10'h020, 10'h001, 32'hFFFF_FFE7,
              0, 8, rl(-61)};
    vt[2] = '{0, 10'h100, 10'h100, '1, 0, 2, 0};
    vt[3] = '{4, 10'h3FE, 10'h004, '1, 5, 7, rl(-40)};
    vt[4] = '{1, 10'h013, 10'h003, '1, 0, 4, rl(-20)};
    vt[5] = '{2, 10'h01E, 10'h006, '1, 0, 5, 98};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_crdy", ba.cmd_ready, 1);
    chk("rst_busy", ba.busy, 0);
    chk("rst_rd", ba.rd_en, 0);
    chk("rst_en", ba.mac_enable, 0);
    chk("rst_clr", ba.mac_clear_acc, 0);
    chk("rst_rv", ba.res_valid, 0);
    chk("rst_data", ba.res_data, 0);
    chk("rst_aa", ba.act_addr, 0);
    chk("rst_wa", ba.wgt_addr, 0);
    chk("rst_crdy_b", bb.cmd_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_cmd(1'b0, vt[i]);

    sel = 1'b1;
    @(negedge clk);
    len = 11'd8;
    ab = 10'h010;
    wb = 10'h200;
    avail = 1'b1;
    cv_b = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cv_b = 1'b0;
      if (c == 4) begin
        abort = 1'b1;
        cv_b = 1'b1;
      end
      #1;
    end
    chk("abort_rd", o_rd, 1);
    chk("abort_idx2", o_aa, 10'h012);
    @(negedge clk);
    abort = 1'b0;
    cv_b = 1'b0;
    #1;
    chk("abort_crdy", o_crdy, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_en", o_en, 0);
    ne = 0;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (o_en) ne++;
      if (o_rv) nv++;
    end
    chk("abort_no_en", ne, 0);
    chk("abort_no_rv", nv, 0);
    run_cmd(1'b1, '{1, 10'h013, 10'h003, '1,
                    0, 6, rl(-20)});
    run_cmd(1'b1, '{4, 10'h010, 10'h200, '1,
                    2, 9, rl(-60)});

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
